// File: rtl/gabor_pkg.sv
// Shared defaults, orientation count and FSM encoding for the Gabor window sequencer.
package gabor_pkg;
   localparam int DEF_IMG_W     = 640;
   localparam int DEF_IMG_H     = 480;
   localparam int DEF_KSIZE     = 5;
   localparam int DEF_PIXEL_W   = 8;
   localparam int DEF_COEFF_W   = 10;
   localparam int DEF_ADDR_W    = 19;
   localparam int DEF_CADDR_W   = 5;
   localparam int DEF_RD_LAT    = 1;
   localparam int DEF_PIXEL_GAP = 4;
   localparam int NUM_ORIENT    = 6;
   localparam int X_W           = 10;
   localparam int Y_W           = 9;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_WAIT_RD, S_LOAD, S_MULT, S_NEXT_TAP, S_GAP, S_DONE
   } state_t;
endpackage

// File: rtl/tap_address_gen.sv
// Window-origin and tap counters; image address is built with adders only,
// tracking the row base, origin base and current kernel-line base.
module tap_address_gen
   import gabor_pkg::*;
#(
   parameter int IMG_W   = DEF_IMG_W,
   parameter int IMG_H   = DEF_IMG_H,
   parameter int KSIZE   = DEF_KSIZE,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int CADDR_W = DEF_CADDR_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               step_tap,
   input  logic               step_origin,
   output logic [ADDR_W-1:0]  addr,
   output logic [CADDR_W-1:0] tap,
   output logic [X_W-1:0]     out_x,
   output logic [Y_W-1:0]     out_y,
   output logic               last_tap,
   output logic               last_origin
);
   localparam int KW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
   localparam logic [KW-1:0]      K_LAST = KW'(KSIZE - 1);
   localparam logic [CADDR_W-1:0] T_LAST = CADDR_W'(KSIZE * KSIZE - 1);
   localparam logic [X_W-1:0]     X_LAST = X_W'(IMG_W - KSIZE);
   localparam logic [Y_W-1:0]     Y_LAST = Y_W'(IMG_H - KSIZE);
   localparam logic [ADDR_W-1:0]  ROW    = ADDR_W'(IMG_W);

   logic [KW-1:0]     kx, ky;
   logic [ADDR_W-1:0] row_base, origin_base, line_base, next_origin;
   logic              x_wrap;

   assign x_wrap      = (out_x == X_LAST);
   assign next_origin = x_wrap ? (row_base + ROW) : (origin_base + 1'b1);
   assign last_tap    = (tap == T_LAST);
   assign last_origin = x_wrap && (out_y == Y_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         kx <= '0; ky <= '0; tap <= '0; out_x <= '0; out_y <= '0;
         row_base <= '0; origin_base <= '0; line_base <= '0; addr <= '0;
      end else if (clear) begin
         kx <= '0; ky <= '0; tap <= '0; out_x <= '0; out_y <= '0;
         row_base <= '0; origin_base <= '0; line_base <= '0; addr <= '0;
      end else if (step_tap) begin
         tap <= tap + 1'b1;
         if (kx == K_LAST) begin
            // kernel row finished: jump to the next image line of the window
            kx        <= '0;
            ky        <= ky + 1'b1;
            line_base <= line_base + ROW;
            addr      <= line_base + ROW;
         end else begin
            kx   <= kx + 1'b1;
            addr <= addr + 1'b1;
         end
      end else if (step_origin) begin
         kx <= '0; ky <= '0; tap <= '0;
         origin_base <= next_origin;
         line_base   <= next_origin;
         addr        <= next_origin;
         if (x_wrap) begin
            out_x    <= '0;
            out_y    <= out_y + 1'b1;
            row_base <= row_base + ROW;
         end else begin
            out_x <= out_x + 1'b1;
         end
      end
   end
endmodule

// File: rtl/gabor_window_sequencer.sv
// Sequences BRAM reads and multiplier handshakes for a valid-only KSIZE x KSIZE
// Gabor convolution over the frame, one tap at a time.
module gabor_window_sequencer
   import gabor_pkg::*;
#(
   parameter int IMG_W     = DEF_IMG_W,
   parameter int IMG_H     = DEF_IMG_H,
   parameter int KSIZE     = DEF_KSIZE,
   parameter int PIXEL_W   = DEF_PIXEL_W,
   parameter int COEFF_W   = DEF_COEFF_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int CADDR_W   = DEF_CADDR_W,
   parameter int RD_LAT    = DEF_RD_LAT,
   parameter int PIXEL_GAP = DEF_PIXEL_GAP
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          conv_ready,
   input  logic                          mult_done,
   input  logic [PIXEL_W-1:0]            image_BRAM_datain,
   input  logic [NUM_ORIENT*COEFF_W-1:0] coeff_datain,
   output logic [ADDR_W-1:0]             image_BRAM_addr,
   output logic [CADDR_W-1:0]            coeff_BRAM_addr,
   output logic [PIXEL_W-1:0]            image_pixel_buf,
   output logic [NUM_ORIENT*COEFF_W-1:0] line_buf_coeff,
   output logic                          start_mul,
   output logic                          data_ready,
   output logic                          busy,
   output logic                          frame_done,
   output logic [X_W-1:0]                out_x,
   output logic [Y_W-1:0]                out_y
);
   localparam logic [7:0] RD_LAST  = 8'((RD_LAT > 1) ? RD_LAT - 1 : 0);
   localparam logic [7:0] GAP_LAST = 8'((PIXEL_GAP > 1) ? PIXEL_GAP - 1 : 0);

   state_t     state;
   logic [7:0] wait_cnt, gap_cnt;
   logic       clear, step_tap, step_origin, last_tap, last_origin;

   // counters restart on frame start and are parked at zero once a frame ends
   assign clear       = ((state == S_IDLE) && start) || (state == S_DONE);
   assign step_tap    = (state == S_NEXT_TAP) && !last_tap;
   assign step_origin = (state == S_GAP) && (gap_cnt == GAP_LAST) && !last_origin;

   tap_address_gen #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .KSIZE(KSIZE), .ADDR_W(ADDR_W), .CADDR_W(CADDR_W)
   ) u_addr (
      .clock(clock), .reset(reset), .clear(clear), .step_tap(step_tap),
      .step_origin(step_origin), .addr(image_BRAM_addr), .tap(coeff_BRAM_addr),
      .out_x(out_x), .out_y(out_y), .last_tap(last_tap), .last_origin(last_origin)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= S_IDLE;
         wait_cnt        <= '0;
         gap_cnt         <= '0;
         image_pixel_buf <= '0;
         line_buf_coeff  <= '0;
         start_mul       <= 1'b0;
         data_ready      <= 1'b0;
         busy            <= 1'b0;
         frame_done      <= 1'b0;
      end else begin
         start_mul  <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               state <= S_ADDR;
               busy  <= 1'b1;
            end
            S_ADDR: begin
               state    <= S_WAIT_RD;
               wait_cnt <= '0;
            end
            S_WAIT_RD: begin
               if (wait_cnt == RD_LAST) state <= S_LOAD;
               else                     wait_cnt <= wait_cnt + 1'b1;
            end
            // operands are captured only when the multiplier can take them
            S_LOAD: if (conv_ready) begin
               image_pixel_buf <= image_BRAM_datain;
               line_buf_coeff  <= coeff_datain;
               start_mul       <= 1'b1;
               data_ready      <= last_tap;
               state           <= S_MULT;
            end
            S_MULT: if (mult_done) begin
               data_ready <= 1'b0;
               state      <= S_NEXT_TAP;
            end
            S_NEXT_TAP: begin
               gap_cnt <= '0;
               state   <= last_tap ? S_GAP : S_ADDR;
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (last_origin) begin
                     state      <= S_DONE;
                     frame_done <= 1'b1;
                  end else begin
                     state <= S_ADDR;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gabor_window_sequencer.sv
// Scoreboard bench: expected taps queued per frame, a negedge monitor pops and
// compares on every start_mul and also models the multiplier.
module tb_gabor_window_sequencer;
   localparam int IMG_W = 8, IMG_H = 6, KS = 5;

   logic        clock = 1'b0, reset = 1'b1, start = 1'b0, conv_ready = 1'b1;
   logic        md_model = 1'b0, spur = 1'b0, mult_done;
   logic [7:0]  image_BRAM_datain = '0;
   logic [59:0] coeff_datain = '0;
   logic [18:0] image_BRAM_addr;
   logic [4:0]  coeff_BRAM_addr;
   logic [7:0]  image_pixel_buf;
   logic [59:0] line_buf_coeff;
   logic        start_mul, data_ready, busy, frame_done;
   logic [9:0]  out_x;
   logic [8:0]  out_y;

   typedef struct {
      logic [18:0] addr;
      logic [4:0]  caddr;
      logic [9:0]  ox;
      logic [8:0]  oy;
      logic        last;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0, errors = 0;
   int sm_cnt = 0, fd_cnt = 0, mcnt = 0;
   logic [18:0] last_addr = '0;
   logic dr_model = 1'b0, fd_prev = 1'b0;

   assign mult_done = md_model | spur;
   always #5 clock = ~clock;

   gabor_window_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .RD_LAT(1)) dut (
      .clock(clock), .reset(reset), .start(start), .conv_ready(conv_ready),
      .mult_done(mult_done), .image_BRAM_datain(image_BRAM_datain),
      .coeff_datain(coeff_datain), .image_BRAM_addr(image_BRAM_addr),
      .coeff_BRAM_addr(coeff_BRAM_addr), .image_pixel_buf(image_pixel_buf),
      .line_buf_coeff(line_buf_coeff), .start_mul(start_mul), .data_ready(data_ready),
      .busy(busy), .frame_done(frame_done), .out_x(out_x), .out_y(out_y)
   );

   function automatic logic [7:0] pix(input logic [18:0] a);
      return a[7:0] ^ 8'hA5;
   endfunction

   function automatic logic [59:0] coef(input logic [4:0] t);
      logic [59:0] c;
      c = '0;
      for (int k = 0; k < 6; k++) c[k*10 +: 10] = 10'(int'(t) * 7 + k * 100 + 3);
      return c;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, act, expv, $time);
      end
   endtask

   // one-cycle-latency BRAM models
   always @(posedge clock) begin
      image_BRAM_datain <= pix(image_BRAM_addr);
      coeff_datain      <= coef(coeff_BRAM_addr);
   end

   always @(negedge clock) begin
      if (reset) begin
         exp_q.delete();
         mcnt = 0; md_model = 1'b0; dr_model = 1'b0;
      end else begin
         if (md_model) begin md_model = 1'b0; dr_model = 1'b0; end
         if (start_mul) begin
            sm_cnt++;
            last_addr = image_BRAM_addr;
            mcnt = 10;
            if (exp_q.size() == 0) chk("unexpected_start_mul", 64'(start_mul), 64'd0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               dr_model = e.last;
               chk("img_addr", 64'(image_BRAM_addr), 64'(e.addr));
               chk("coeff_addr", 64'(coeff_BRAM_addr), 64'(e.caddr));
               chk("origin", 64'({out_x, out_y}), 64'({e.ox, e.oy}));
               chk("pixel_buf", 64'(image_pixel_buf), 64'(pix(e.addr)));
               chk("coeff_buf", 64'(line_buf_coeff), 64'(coef(e.caddr)));
            end
         end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) md_model = 1'b1;
         end
         if (frame_done) begin
            fd_cnt++;
            chk("frame_done_width", 64'(fd_prev), 64'd0);
         end
      end
      chk("data_ready", 64'(data_ready), 64'(dr_model));
      fd_prev = frame_done;
   end

   task automatic push_frame();
      for (int oy = 0; oy <= IMG_H - KS; oy++)
         for (int ox = 0; ox <= IMG_W - KS; ox++)
            for (int t = 0; t < KS * KS; t++) begin
               exp_t e;
               e.addr  = 19'((oy + t / KS) * IMG_W + ox + t % KS);
               e.caddr = 5'(t);
               e.ox    = 10'(ox);
               e.oy    = 9'(oy);
               e.last  = (t == KS * KS - 1);
               exp_q.push_back(e);
            end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 6000) begin @(posedge clock); #1; n++; end
      chk(name, 64'(busy), 64'd0);
   endtask

   task automatic wait_tap(input logic [4:0] t, input logic [9:0] x, input logic [8:0] y);
      int n;
      n = 0;
      while (!(start_mul && coeff_BRAM_addr == t && out_x == x && out_y == y) && n < 6000) begin
         @(posedge clock); #1; n++;
      end
      chk("wait_tap_timeout", 64'(n < 6000), 64'd1);
   endtask

   task automatic frame_tail(input int sm_base, input int fd_base);
      chk("start_mul_count", 64'(sm_cnt - sm_base), 64'd200);
      chk("frame_done_count", 64'(fd_cnt - fd_base), 64'd1);
      chk("last_tap_addr", 64'(last_addr), 64'd47);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int smb, fdb, n, inj;
      logic [4:0] prev_c;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_ctl", 64'({start_mul, data_ready, busy, frame_done}), 64'd0);
      chk("rst_addr", 64'({image_BRAM_addr, coeff_BRAM_addr}), 64'd0);
      chk("rst_bufs", 64'({image_pixel_buf, line_buf_coeff}), 64'd0);
      chk("rst_xy", 64'({out_x, out_y}), 64'd0);
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;

      // plain frame
      smb = sm_cnt; fdb = fd_cnt;
      push_frame();
      pulse_start();
      chk("busy_after_start", 64'(busy), 64'd1);
      wait_idle("frame1_end");
      frame_tail(smb, fdb);

      // conv_ready stall at tap 5 of origin (0,0)
      smb = sm_cnt; fdb = fd_cnt;
      push_frame();
      pulse_start();
      wait_tap(5'd4, 10'd0, 9'd0);
      conv_ready = 1'b0;
      n = 0;
      while (coeff_BRAM_addr != 5'd5 && n < 100) begin @(posedge clock); #1; n++; end
      chk("reach_tap5", 64'(coeff_BRAM_addr), 64'd5);
      repeat (2) @(posedge clock);
      #1;
      for (int i = 0; i < 7; i++) begin
         chk("stall_frozen", 64'({start_mul, image_pixel_buf, image_BRAM_addr, coeff_BRAM_addr}),
             64'({1'b0, pix(19'd4), 19'd8, 5'd5}));
         @(posedge clock); #1;
      end
      conv_ready = 1'b1;
      @(posedge clock); #1;
      chk("stall_release_start_mul", 64'({start_mul, image_pixel_buf}), 64'({1'b1, pix(19'd8)}));
      wait_idle("frame2_end");
      frame_tail(smb, fdb);

      // spurious mult_done in ADDR and start pulses mid-frame
      smb = sm_cnt; fdb = fd_cnt;
      push_frame();
      pulse_start();
      prev_c = coeff_BRAM_addr; n = 0; inj = 0;
      while (busy && n < 6000) begin
         spur  = 1'b0;
         start = (n == 100 || n == 1500);
         if (coeff_BRAM_addr != prev_c && inj < 8) begin spur = 1'b1; inj++; end
         prev_c = coeff_BRAM_addr;
         @(posedge clock); #1; n++;
      end
      spur = 1'b0; start = 1'b0;
      chk("frame3_end", 64'(busy), 64'd0);
      frame_tail(smb, fdb);

      // reset during MULT of origin (2,0)
      push_frame();
      pulse_start();
      wait_tap(5'd0, 10'd2, 9'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      chk("arst_ctl", 64'({start_mul, data_ready, busy, frame_done}), 64'd0);
      chk("arst_addr", 64'({image_BRAM_addr, coeff_BRAM_addr}), 64'd0);
      chk("arst_bufs", 64'({image_pixel_buf, line_buf_coeff}), 64'd0);
      chk("arst_xy", 64'({out_x, out_y}), 64'd0);
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      smb = sm_cnt;
      repeat (30) @(posedge clock);
      #1;
      chk("no_start_mul_after_reset", 64'(sm_cnt - smb), 64'd0);
      chk("idle_after_reset", 64'(busy), 64'd0);

      // rerun from the beginning
      smb = sm_cnt; fdb = fd_cnt;
      push_frame();
      pulse_start();
      wait_idle("frame5_end");
      frame_tail(smb, fdb);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
